// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer pot scanner.
package eq_pkg;

   localparam int unsigned NUM_POTS    = 6;
   localparam logic [11:0] POT_RST_MID = 12'h800;

   typedef enum logic [2:0] {
      SLOT_LP  = 3'd0,
      SLOT_B1  = 3'd1,
      SLOT_B2  = 3'd2,
      SLOT_B3  = 3'd3,
      SLOT_HP  = 3'd4,
      SLOT_VOL = 3'd5
   } slot_e;

   // A2D channel wired to each slot; entry 0 (rightmost) is SLOT_LP.
   localparam logic [NUM_POTS-1:0][2:0] A2D_CHNL_MAP = {3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1};

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StWait,
      StGap
   } scan_state_e;

   // Band pots come up at unity gain, volume comes up muted.
   function automatic logic [11:0] pot_rst_val(input slot_e slot);
      return (slot == SLOT_VOL) ? 12'h000 : POT_RST_MID;
   endfunction

endpackage

// File: rtl/pot_regfile.sv
// Six 12-bit pot registers written by slot index.
// Build option POT_AVG_EN: 2-tap smoothing of each capture after the first.
module pot_regfile
   import eq_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we,
   input  logic [2:0]             wr_slot,
   input  logic [11:0]            wr_data,
   output logic [NUM_POTS*12-1:0] pots
);

   logic [11:0] pot_q [NUM_POTS];
   logic [11:0] pot_d [NUM_POTS];

`ifdef POT_AVG_EN
   logic [NUM_POTS-1:0] primed_q, primed_d;
   logic [12:0]         sum;

   always_comb begin
      primed_d = primed_q;
      sum      = '0;
      for (int i = 0; i < NUM_POTS; i++) begin
         pot_d[i] = pot_q[i];
         if (we && wr_slot == 3'(i)) begin
            sum         = {1'b0, pot_q[i]} + {1'b0, wr_data} + 13'd1;
            pot_d[i]    = primed_q[i] ? 12'(sum >> 1) : wr_data;
            primed_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         primed_q <= '0;
      end else begin
         primed_q <= primed_d;
      end
   end
`else
   always_comb begin
      for (int i = 0; i < NUM_POTS; i++) begin
         pot_d[i] = pot_q[i];
         if (we && wr_slot == 3'(i)) begin
            pot_d[i] = wr_data;
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_POTS; i++) begin
            pot_q[i] <= pot_rst_val(slot_e'(3'(i)));
         end
      end else begin
         for (int i = 0; i < NUM_POTS; i++) begin
            pot_q[i] <= pot_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_POTS; i++) begin
         pots[i*12 +: 12] = pot_q[i];
      end
   end

endmodule

// File: rtl/pot_scan_seq.sv
// Round-robin scheduler sharing one A2D converter among the six slide pots.
// Build option POT_AVG_EN (in pot_regfile) smooths captured values.
module pot_scan_seq
   import eq_pkg::*;
#(
   parameter int unsigned ROUND_GAP     = 1024,
   parameter int unsigned CMPLT_TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        strt_cnv,
   output logic [2:0]  chnnl,
   input  logic        cnv_cmplt,
   input  logic [11:0] res,
   input  logic        clr_err,
   output logic [11:0] LP_pot,
   output logic [11:0] B1_pot,
   output logic [11:0] B2_pot,
   output logic [11:0] B3_pot,
   output logic [11:0] HP_pot,
   output logic [11:0] VOL_pot,
   output logic        pots_vld,
   output logic        seq_err
);

   // One counter serves both the WAIT timeout and the GAP delay.
   localparam int unsigned CntMax =
      (CMPLT_TIMEOUT > ROUND_GAP + 1) ? CMPLT_TIMEOUT : ROUND_GAP + 1;
   localparam int unsigned CntW = $clog2(CntMax);
   localparam logic [CntW-1:0] TmoLast = CntW'(CMPLT_TIMEOUT - 1);
   localparam logic [CntW-1:0] GapLast = CntW'(ROUND_GAP);

   scan_state_e     state_q, state_d;
   slot_e           slot_q, slot_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            strt_cnv_q, strt_cnv_d;
   logic [2:0]      chnnl_q, chnnl_d;
   logic            pots_vld_q, pots_vld_d;
   logic            seq_err_q, seq_err_d;
   logic            cap, timeout;
   logic [NUM_POTS*12-1:0] pots;

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      cnt_d      = cnt_q + CntW'(1);
      pots_vld_d = 1'b0;
      seq_err_d  = seq_err_q;
      cap        = (state_q == StWait) && cnv_cmplt;
      timeout    = (state_q == StWait) && !cnv_cmplt && (cnt_q == TmoLast);

      unique case (state_q)
         StIdle: begin
            slot_d = SLOT_LP;
            cnt_d  = '0;
            if (en) state_d = StStart;
         end
         StStart: state_d = StWait;
         StWait: begin
            // A timeout finishes the slot exactly like a completed conversion.
            if (cap || timeout) begin
               if (slot_q == SLOT_VOL) begin
                  pots_vld_d = 1'b1;
                  slot_d     = SLOT_LP;
                  state_d    = StGap;
               end else if (en) begin
                  slot_d  = slot_e'(slot_q + 3'd1);
                  state_d = StStart;
               end else begin
                  slot_d  = SLOT_LP;
                  state_d = StIdle;
               end
            end
         end
         StGap: begin
            if (!en) state_d = StIdle;
            else if (cnt_q == GapLast) state_d = StStart;
         end
         default: state_d = StIdle;
      endcase

      // START->WAIT keeps counting so the timeout is measured from the request.
      if (state_d != state_q && state_d != StWait) cnt_d = '0;

      if (timeout) seq_err_d = 1'b1;
      else if (clr_err) seq_err_d = 1'b0;

      strt_cnv_d = (state_d == StStart);
      chnnl_d    = A2D_CHNL_MAP[slot_d];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         slot_q     <= SLOT_LP;
         cnt_q      <= '0;
         strt_cnv_q <= 1'b0;
         chnnl_q    <= 3'd0;
         pots_vld_q <= 1'b0;
         seq_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         cnt_q      <= cnt_d;
         strt_cnv_q <= strt_cnv_d;
         chnnl_q    <= chnnl_d;
         pots_vld_q <= pots_vld_d;
         seq_err_q  <= seq_err_d;
      end
   end

   pot_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (cap),
      .wr_slot (slot_q),
      .wr_data (res),
      .pots    (pots)
   );

   assign strt_cnv = strt_cnv_q;
   assign chnnl    = chnnl_q;
   assign pots_vld = pots_vld_q;
   assign seq_err  = seq_err_q;
   assign LP_pot   = pots[0*12 +: 12];
   assign B1_pot   = pots[1*12 +: 12];
   assign B2_pot   = pots[2*12 +: 12];
   assign B3_pot   = pots[3*12 +: 12];
   assign HP_pot   = pots[4*12 +: 12];
   assign VOL_pot  = pots[5*12 +: 12];

endmodule

// File: tb/tb_pot_scan_seq.sv
// Self-checking bench for pot_scan_seq: A2D responder, scoreboard and directed corner cases.
module tb_pot_scan_seq;
   import eq_pkg::*;

   localparam int unsigned GAP = 20;
   localparam int unsigned TMO = 100;
   localparam int unsigned LAT = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        cnv_cmplt = 1'b0;
   logic        clr_err = 1'b0;
   logic [11:0] res = '0;
   logic        strt_cnv, pots_vld, seq_err;
   logic [2:0]  chnnl;
   logic [11:0] lp, b1, b2, b3, hp, vol;

   pot_scan_seq #(
      .ROUND_GAP     (GAP),
      .CMPLT_TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .strt_cnv  (strt_cnv),
      .chnnl     (chnnl),
      .cnv_cmplt (cnv_cmplt),
      .res       (res),
      .clr_err   (clr_err),
      .LP_pot    (lp),
      .B1_pot    (b1),
      .B2_pot    (b2),
      .B3_pot    (b3),
      .HP_pot    (hp),
      .VOL_pot   (vol),
      .pots_vld  (pots_vld),
      .seq_err   (seq_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          slot;
      logic [11:0] val;
   } sb_t;

   typedef struct {
      logic        cmplt;
      logic [11:0] rv;
      logic        clr;
      logic [2:0]  exp_chnnl;
      logic        exp_err;
   } vec_t;

   sb_t         sb_q[$];
   logic [2:0]  exp_ch[$];
   logic [11:0] ref_pot [NUM_POTS];
   bit          ref_primed [NUM_POTS];
   logic [11:0] resp [8];
   bit          drop [8];
   bit          a2d_on = 1'b1;
   int          vld_cnt = 0;
   int          strt_cnt = 0;
   int          chmap [NUM_POTS] = '{1, 0, 4, 2, 3, 7};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout want event", name);
   endtask

   function automatic logic [11:0] pot_of(input int s);
      case (s)
         0: return lp;
         1: return b1;
         2: return b2;
         3: return b3;
         4: return hp;
         default: return vol;
      endcase
   endfunction

   function automatic int ch2slot(input logic [2:0] ch);
      case (ch)
         3'd1: return 0;
         3'd0: return 1;
         3'd4: return 2;
         3'd2: return 3;
         3'd3: return 4;
         default: return 5;
      endcase
   endfunction

   function automatic logic [11:0] model_cap(input logic [11:0] old, input logic [11:0] val,
                                             input bit primed);
`ifdef POT_AVG_EN
      logic [12:0] s;
      s = {1'b0, old} + {1'b0, val} + 13'd1;
      return primed ? s[12:1] : val;
`else
      return val;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_POTS; i++) begin
         ref_pot[i]    = (i == NUM_POTS - 1) ? 12'h000 : 12'h800;
         ref_primed[i] = 1'b0;
      end
   endtask

   // Called just after a posedge; cnv_cmplt is high for exactly one cycle.
   task automatic drive_cmplt(input logic [2:0] ch, input logic [11:0] val, input bit cap);
      sb_t e;
      e.slot = ch2slot(ch);
      if (cap) begin
         ref_pot[e.slot]    = model_cap(ref_pot[e.slot], val, ref_primed[e.slot]);
         ref_primed[e.slot] = 1'b1;
      end
      e.val = ref_pot[e.slot];
      sb_q.push_back(e);
      cnv_cmplt = 1'b1;
      res       = val;
      @(posedge clk);
      #1;
      cnv_cmplt = 1'b0;
   endtask

   always begin : a2d_model
      logic [2:0] ch;
      @(negedge clk);
      if (strt_cnv && a2d_on && !rst) begin
         ch = chnnl;
         if (!drop[ch]) begin
            repeat (LAT) @(posedge clk);
            #1;
            drive_cmplt(ch, resp[ch], 1'b1);
         end
      end
   end

   bit cmplt_seen = 1'b0;
   always @(negedge clk) begin : monitor
      sb_t e;
      if (!rst) begin
         if (cmplt_seen && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("sb_pot%0d", e.slot), pot_of(e.slot), e.val);
         end
         if (strt_cnv) begin
            strt_cnt <= strt_cnt + 1;
            if (exp_ch.size() == 0) check("extra_strt", strt_cnv, 1'b0);
            else check("chnnl_seq", chnnl, exp_ch.pop_front());
         end
         if (pots_vld) vld_cnt <= vld_cnt + 1;
      end
      cmplt_seen <= cnv_cmplt && !rst;
   end

   task automatic wait_vld(input string name, input int max, output int at);
      int i;
      at = -1;
      for (i = 0; i < max; i++) begin
         @(negedge clk);
         if (pots_vld) break;
      end
      if (i == max) tmo(name);
      else at = cyc;
   endtask

   task automatic wait_strt(input string name, input int max, input int want, output int at);
      int i;
      at = -1;
      for (i = 0; i < max; i++) begin
         @(negedge clk);
         if (strt_cnv && (want < 0 || int'(chnnl) == want)) break;
      end
      if (i == max) tmo(name);
      else at = cyc;
   endtask

   task automatic push_round();
      for (int s = 0; s < NUM_POTS; s++) exp_ch.push_back(3'(chmap[s]));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_strt"}, strt_cnv, 1'b0);
      check({tag, "_vld"}, pots_vld, 1'b0);
      check({tag, "_err"}, seq_err, 1'b0);
      for (int s = 0; s < NUM_POTS; s++)
         check($sformatf("%s_pot%0d", tag, s), pot_of(s), (s == 5) ? 12'h000 : 12'h800);
   endtask

   initial begin : main
      vec_t vecs [6];
      int   p, q, s2, at, v0, sc0;

      vecs[0] = '{1'b0, 12'h000, 1'b0, 3'd1, 1'b0};
      vecs[1] = '{1'b1, 12'hABC, 1'b0, 3'd1, 1'b0};
      vecs[2] = '{1'b0, 12'h123, 1'b1, 3'd1, 1'b0};
      vecs[3] = '{1'b1, 12'hFFF, 1'b1, 3'd1, 1'b0};
      vecs[4] = '{1'b1, 12'h001, 1'b0, 3'd1, 1'b0};
      vecs[5] = '{1'b0, 12'h000, 1'b0, 3'd1, 1'b0};

      model_reset();
      for (int c = 0; c < 8; c++) begin
         resp[c] = '0;
         drop[c] = 1'b0;
      end

      // Reset state and idle behaviour
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_chnnl", chnnl, 3'd0);
      check_reset_outputs("rst");
      @(posedge clk);
      #1 rst = 1'b0;
      for (int v = 0; v < 6; v++) begin
         cnv_cmplt = vecs[v].cmplt;
         res       = vecs[v].rv;
         clr_err   = vecs[v].clr;
         @(posedge clk);
         #1;
         cnv_cmplt = 1'b0;
         clr_err   = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_chnnl", v), chnnl, vecs[v].exp_chnnl);
         check($sformatf("vec%0d_err", v), seq_err, vecs[v].exp_err);
         check($sformatf("vec%0d_strt", v), strt_cnv, 1'b0);
         check($sformatf("vec%0d_lp", v), lp, 12'h800);
         check($sformatf("vec%0d_vol", v), vol, 12'h000);
      end
      repeat (5000) @(negedge clk);
      check("idle_strt_cnt", strt_cnt, 0);
      check("idle_vld_cnt", vld_cnt, 0);

      // Full round
      for (int s = 0; s < NUM_POTS; s++) resp[chmap[s]] = 12'((s + 1) * 256);
      push_round();
      exp_ch.push_back(3'd1);
      v0 = vld_cnt;
      @(posedge clk);
      #1 en = 1'b1;
      wait_vld("round_vld", 2000, p);
      for (int s = 0; s < NUM_POTS; s++)
         check($sformatf("round_pot%0d", s), pot_of(s), 12'((s + 1) * 256));
      wait_strt("round2_strt", 200, -1, q);
      check("gap_latency", q - p, GAP + 1);
      en = 1'b0;
      repeat (LAT + 20) @(negedge clk);
      check("round_vld_cnt", vld_cnt - v0, 1);

      // Timeout on B2, then timeout coinciding with clr_err
      for (int s = 0; s < NUM_POTS; s++) resp[chmap[s]] = 12'h A01 + 12'(s);
      drop[4] = 1'b1;
      push_round();
      @(posedge clk);
      #1 en = 1'b1;
      wait_strt("b2_strt", 500, 4, s2);
      at = -1;
      for (int i = 0; i < int'(TMO) + 20; i++) begin
         @(negedge clk);
         if (seq_err) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) tmo("tmo_seq_err");
      check("tmo_latency", at - s2, TMO);
      check("tmo_b2_hold", b2, 12'h300);
      check("tmo_b3_strt", strt_cnv, 1'b1);
      check("tmo_b3_chnnl", chnnl, 3'd2);
      wait_vld("tmo_vld", 1000, p);
      push_round();
      @(posedge clk);
      #1 clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      @(negedge clk);
      check("clr_err", seq_err, 1'b0);
      wait_strt("b2_strt_r2", 500, 4, s2);
      while (cyc < s2 + int'(TMO) - 1) begin
         @(posedge clk);
         #1;
      end
      clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      @(negedge clk);
      check("tmo_beats_clr", seq_err, 1'b1);
      check("tmo_r2_b3_strt", strt_cnv, 1'b1);
      wait_vld("tmo_vld_r2", 1000, p);
      en = 1'b0;
      drop[4] = 1'b0;
      repeat (GAP + 60) @(negedge clk);
      check("b2_hold_r2", b2, 12'h300);

      // en dropped while waiting on B1
      resp[0] = 12'h2BC;
      exp_ch.push_back(3'd1);
      exp_ch.push_back(3'd0);
      v0 = vld_cnt;
      @(posedge clk);
      #1 en = 1'b1;
      wait_strt("b1_strt", 200, 0, q);
      repeat (10) @(negedge clk);
      en = 1'b0;
      sc0 = strt_cnt;
      repeat (LAT + 100) @(negedge clk);
      check("b1_capt", b1, ref_pot[1]);
      check("b1_no_strt", strt_cnt - sc0, 0);
      check("b1_no_vld", vld_cnt - v0, 0);
      a2d_on = 1'b0;
      exp_ch.push_back(3'd1);
      @(posedge clk);
      #1 en = 1'b1;
      wait_strt("reen_strt", 50, -1, q);
      check("reen_chnnl", chnnl, 3'd1);

      // Async reset while waiting, late cnv_cmplt after release
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1;
      en  = 1'b0;
      model_reset();
      @(negedge clk);
      check("mid_rst_chnnl", chnnl, 3'd0);
      check_reset_outputs("mid_rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      drive_cmplt(3'd1, 12'hFFF, 1'b0);
      @(negedge clk);
      check_reset_outputs("late_cmplt");
      repeat (50) @(negedge clk);

      // Two rounds from reset: direct capture, then smoothed capture if enabled
      a2d_on = 1'b1;
      for (int s = 0; s < NUM_POTS; s++) resp[chmap[s]] = 12'((s + 1) * 12'h111);
      resp[1] = 12'h400;
      push_round();
      push_round();
      @(posedge clk);
      #1 en = 1'b1;
      wait_vld("avg_vld1", 2000, p);
      check("avg_r1_lp", lp, 12'h400);
      resp[1] = 12'h801;
      wait_vld("avg_vld2", 2000, p);
`ifdef POT_AVG_EN
      check("avg_r2_lp", lp, 12'h601);
`else
      check("avg_r2_lp", lp, 12'h801);
`endif
      check("avg_r2_hp", hp, 12'h555);
      en = 1'b0;
      repeat (GAP + 20) @(negedge clk);
      check("exp_ch_drained", exp_ch.size(), 0);
      check("sb_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pot_scan_seq.md
Name: pot_scan_seq

Overview:
- Round-robin scheduler that shares the single SPI A2D converter among the six slide pots: LP, B1, B2, B3, HP and VOL.
- Issues one conversion request per pot, captures each 12-bit result into a per-band register, then idles for a programmable gap before the next round.
- Sits between the A2D SPI interface block and the band-gain/volume datapath of the equalizer.
- Detects a stalled converter via timeout and flags it.

Parameters:
- ROUND_GAP, 1024: idle clk cycles between the end of one round and the start of the next (min 1).
- CMPLT_TIMEOUT, 4096: max clk cycles to wait for cnv_cmplt after a request.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  scan enable
- strt_cnv  out  1  one-cycle conversion request to the A2D interface
- chnnl  out  3  A2D channel for the current request
- cnv_cmplt  in  1  one-cycle pulse; conversion finished and res is valid
- res  in  12  conversion result
- clr_err  in  1  clears seq_err
- LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, VOL_pot  out  12 each  latest pot values
- pots_vld  out  1  one-cycle pulse when a round completes
- seq_err  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - state IDLE, slot index 0, strt_cnv=0, chnnl=0, pots_vld=0, seq_err=0.
  - LP/B1/B2/B3/HP_pot = 12'h800 (unity gain); VOL_pot = 12'h000 (muted).
- Slot order 0..5 = LP, B1, B2, B3, HP, VOL. A2D channel map = 1, 0, 4, 2, 3, 7.
- chnnl is registered and always equals the map entry of the current slot.
- State machine (Moore), states IDLE, START, WAIT, GAP:
  - IDLE: if en, go to START. Slot index = 0.
  - START: lasts exactly one cycle; strt_cnv=1; then WAIT. Timeout counter cleared.
  - WAIT: on cnv_cmplt, write res into the current slot's pot register. The new value is visible on the cycle after the cnv_cmplt edge.
    - If slot < 5 and en: slot+1, go to START.
    - If slot == 5: pots_vld=1 for one cycle (the cycle the VOL value becomes visible), slot=0, go to GAP.
    - If en is low after a capture: slot=0, go to IDLE. No pots_vld unless slot was 5.
  - GAP: counts ROUND_GAP cycles, then goes to START if en, else IDLE. en falling during GAP: go to IDLE next cycle.
- Request-to-request latency within a round: cnv_cmplt cycle + 1 = START.
- Timeout: WAIT counter reaches CMPLT_TIMEOUT-1 without cnv_cmplt.
  - seq_err set; pot register unchanged.
  - Proceeds exactly as if cnv_cmplt had arrived, including the pots_vld pulse at slot 5.
- cnv_cmplt outside WAIT is ignored; no capture.
- en deasserted in START or WAIT: the outstanding conversion is completed or timed out first. The SPI transaction is never abandoned.
- clr_err clears seq_err on the next edge. If a timeout and clr_err occur in the same cycle, set wins.
- rst mid-round: immediate return to reset values. A late cnv_cmplt arriving after reset release is ignored (state is IDLE).
- Counters sized with $clog2 of their parameters. No arithmetic wrap occurs, because counters clear on every state entry.

Optional Feature:
- Macro POT_AVG_EN.
  - Defined: capture writes (old + res + 1) >> 1 using a 13-bit sum, i.e. a 2-tap smoothing filter. The first capture after reset writes res directly, tracked by a per-slot "primed" bit.
  - Undefined: capture writes res directly; no primed bits are synthesized.

Decomposition:
- Shared package eq_pkg:
  - slot enum (SLOT_LP..SLOT_VOL)
  - NUM_POTS = 6
  - A2D channel map constant array
  - POT_RST_MID = 12'h800
  - scan state enum
- One natural sub-module: pot_regfile. Holds the six 12-bit registers, reset values, write-enable by slot index, and the POT_AVG_EN averaging. The FSM stays in pot_scan_seq.

Test Plan:
- Reset/idle: rst high, en=0 → pots read 800,800,800,800,800,000; strt_cnv never pulses over 5000 cycles.
- Full round: en=1, A2D model returns 12'h100 × (slot+1) after 40 cycles each →
  - strt_cnv pulses with chnnl sequence 1,0,4,2,3,7;
  - pots end at 100,200,300,400,500,600;
  - one pots_vld pulse;
  - next strt_cnv exactly ROUND_GAP+1 cycles after pots_vld.
- Timeout: no cnv_cmplt on the B2 slot →
  - seq_err rises at CMPLT_TIMEOUT cycles after its strt_cnv;
  - B2_pot is unchanged; the B3 request follows the next cycle.
  - Then clr_err and the timeout in the same cycle → seq_err stays 1.
- en dropped mid-WAIT on the B1 slot → B1 still captured; no further strt_cnv; re-enable restarts at LP (chnnl=1).
- Async reset asserted in WAIT, with cnv_cmplt 3 cycles after release → no pot change, outputs at reset values.
- POT_AVG_EN: LP returns 12'h400 then 12'h801 →
  - LP_pot = 400 after round 1;
  - LP_pot = 601 after round 2.
